// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM state encoding for the bit-serial adder
package serial_adder_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder shared across all operand bits
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: steps one full-adder cell LSB-first over a WIDTH-bit operand pair
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_w;
  logic [CW-1:0] bit_cnt;
  logic carry, s, co, last, accept;
  fa_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(s), .co(co));
  assign busy   = state == S_RUN;
  assign done   = state == S_DONE;
  assign last   = bit_cnt == CW'(WIDTH - 1);
  assign accept = start && !busy;
  assign acc_w  = {s, acc};
  always_comb begin
    state_n = busy ? (last ? S_DONE : S_RUN) : (start ? S_RUN : S_IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        carry   <= cin;
        bit_cnt <= '0;
      end else if (busy) begin
        acc     <= acc_w[WIDTH-1:1];
        carry   <= co;
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        bit_cnt <= bit_cnt + 1'b1;
        if (last) begin
          sum  <= acc_w;
          cout <= co;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random jobs checked against plain a+b+cin arithmetic
module tb_serial_adder_ctrl;
  logic clk = 0;
  logic rst_n, start, cin;
  logic [7:0] a, b;
  logic busy, done, cout;
  logic [7:0] sum;
  int errs = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic job(input logic [7:0] x, input logic [7:0] y, input logic c, input int poke, input string tag);
    logic [8:0] exp;
    int lat, bc, dn, nd;
    bit ov;
    exp = 9'(x) + 9'(y) + 9'(c);
    start = 1; a = x; b = y; cin = c;
    lat = 0; bc = 0; dn = 0; nd = 0; ov = 0;
    while (dn == 0 && lat < 20) begin
      @(negedge clk);
      lat++;
      start = (poke != 0 && lat == poke);
      if (start) begin a = 8'hFF; b = 8'hFF; cin = 1; end
      if (busy) bc++;
      if (busy && done) ov = 1;
      if (done) begin dn = lat; nd++; end
    end
    chk({tag, "_latency"}, dn, 9);
    chk({tag, "_busy_cycles"}, bc, 8);
    chk({tag, "_busy_done_overlap"}, 32'(ov), 0);
    chk({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(exp[8]));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(exp[7:0]));
  endtask

  initial begin
    int d;
    bit seen;
    rst_n = 0; start = 0; a = 0; b = 0; cin = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    job(8'h00, 8'h00, 0, 0, "zero");
    job(8'hFF, 8'h01, 0, 0, "ff_plus_1");
    job(8'hA5, 8'h5A, 1, 0, "a5_5a_c1");
    job(8'h3C, 8'h0F, 0, 0, "3c_0f");
    job(8'h10, 8'h20, 0, 3, "ignored_start");
    start = 1; a = 8'h55; b = 8'h66; cin = 0;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("abort_no_activity", 32'(seen), 0);
    job(8'h01, 8'h01, 0, 0, "after_abort");
    start = 1; a = 8'h80; b = 8'h80; cin = 0;
    @(negedge clk);
    a = 8'h7F; b = 8'h01;
    d = 1;
    while (!done && d < 20) begin @(negedge clk); d++; end
    chk("b2b_first_latency", d, 9);
    chk("b2b_first_sum", 32'(sum), 32'h00);
    chk("b2b_first_cout", 32'(cout), 1);
    d = 0;
    @(negedge clk);
    d++;
    start = 0;
    while (!done && d < 20) begin @(negedge clk); d++; end
    chk("b2b_gap", d, 9);
    chk("b2b_second_sum", 32'(sum), 32'h80);
    chk("b2b_second_cout", 32'(cout), 0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      job(8'($urandom), 8'($urandom), 1'($urandom), 0, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
